// File: rtl/turn_signal_pkg.sv
// Shared types and constants for the turn-signal sequencer.
// Lamp drives are active-low: LAMP_ON drives a lamp lit, LAMP_OFF leaves it dark.
package turn_signal_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2,
    HAZARD = 2'd3
  } state_t;

  localparam logic LAMP_OFF = 1'b1;
  localparam logic LAMP_ON  = 1'b0;

endpackage

// File: rtl/turn_signal_seq_tick_gen.sv
// tick_gen: free-running prescaler counting 0..TICK_DIV-1.
// tick is high for the whole cycle in which the counter holds its terminal count.
module tick_gen #(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic Clk,
  input  logic Res,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  // Prescaler counter: wraps to 0 after the terminal count, cleared by reset.
  always_ff @(posedge Clk) begin
    if (!Res) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/turn_signal_seq.sv
// turn_signal_seq: sequential turn-signal / hazard lamp controller.
// Optional feature macro: TURN_SIGNAL_BRAKE_EN adds a Brake input that forces
// every side not being sequenced by LEFT/RIGHT fully lit (HAZARD takes priority).
module turn_signal_seq
  import turn_signal_pkg::*;
#(
  parameter int unsigned LAMPS    = 3,
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic             Clk,
  input  logic             Res,
  input  logic             L,
  input  logic             R,
`ifdef TURN_SIGNAL_BRAKE_EN
  input  logic             Brake,
`endif
  output logic [LAMPS-1:0] LampL,
  output logic [LAMPS-1:0] LampR,
  output logic [1:0]       Mode
);

  localparam int unsigned SW = $clog2(LAMPS + 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(LAMPS);

  state_t           state, state_next;
  logic [SW-1:0]    step, step_next;
  logic [LAMPS-1:0] seq;
  logic [LAMPS-1:0] lamp_l_next, lamp_r_next;
  logic             tick;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .Clk  (Clk),
    .Res  (Res),
    .tick (tick)
  );

  // State and step registers.
  always_ff @(posedge Clk) begin
    if (!Res) begin
      state <= IDLE;
      step  <= '0;
    end else begin
      state <= state_next;
      step  <= step_next;
    end
  end

  // Next state from the request levels and step advance, both only on tick.
  always_comb begin
    state_next = state;
    step_next  = step;
    if (tick) begin
      unique case ({L, R})
        2'b11:   state_next = HAZARD;
        2'b10:   state_next = LEFT;
        2'b01:   state_next = RIGHT;
        default: state_next = IDLE;
      endcase
      if (state_next != state) begin
        step_next = '0;
      end else if (state == HAZARD) begin
        step_next = (step == SW'(1)) ? '0 : step + SW'(1);
      end else begin
        step_next = (step == LAST_STEP) ? '0 : step + SW'(1);
      end
    end
  end

  // Lamp decode from the upcoming state/step so the output registers
  // show the new pattern on the cycle right after the tick.
  always_comb begin
    seq         = {LAMPS{LAMP_OFF}};
    lamp_l_next = {LAMPS{LAMP_OFF}};
    lamp_r_next = {LAMPS{LAMP_OFF}};
    for (int unsigned i = 0; i < LAMPS; i++) begin
      if ((step_next != LAST_STEP) && (SW'(i) <= step_next)) begin
        seq[i] = LAMP_ON;
      end
    end
    unique case (state_next)
      LEFT:    lamp_l_next = seq;
      RIGHT:   lamp_r_next = seq;
      HAZARD: begin
        lamp_l_next = (step_next == '0) ? {LAMPS{LAMP_ON}} : {LAMPS{LAMP_OFF}};
        lamp_r_next = (step_next == '0) ? {LAMPS{LAMP_ON}} : {LAMPS{LAMP_OFF}};
      end
      default: ;
    endcase
`ifdef TURN_SIGNAL_BRAKE_EN
    if (Brake && (state_next != HAZARD)) begin
      if (state_next != LEFT) begin
        lamp_l_next = {LAMPS{LAMP_ON}};
      end
      if (state_next != RIGHT) begin
        lamp_r_next = {LAMPS{LAMP_ON}};
      end
    end
`endif
  end

  // Registered outputs.
  always_ff @(posedge Clk) begin
    if (!Res) begin
      LampL <= {LAMPS{LAMP_OFF}};
      LampR <= {LAMPS{LAMP_OFF}};
      Mode  <= IDLE;
    end else begin
      LampL <= lamp_l_next;
      LampR <= lamp_r_next;
      Mode  <= state_next;
    end
  end

endmodule

// File: tb/tb_turn_signal_seq.sv
// Scoreboard testbench for turn_signal_seq (LAMPS=3, TICK_DIV=2).
// Honours TURN_SIGNAL_BRAKE_EN to exercise the Brake input.
module tb_turn_signal_seq;

  localparam int LAMPS = 3;
  localparam int TD    = 2;
  localparam int FULL  = (1 << LAMPS) - 1;

  logic             Clk = 1'b0;
  logic             Res = 1'b0;
  logic             L   = 1'b0;
  logic             R   = 1'b0;
  logic             Brake = 1'b0;
  logic [LAMPS-1:0] LampL, LampR;
  logic [1:0]       Mode;

  int tests  = 0;
  int failed = 0;

  // Reference model: time in ticks, mode as plain integer 0..3, step counter.
  int m_phase = 0;
  int m_mode  = 0;
  int m_step  = 0;
  logic [7:0] exp_q[$];

  turn_signal_seq #(
    .LAMPS    (LAMPS),
    .TICK_DIV (TD)
  ) dut (
    .Clk   (Clk),
    .Res   (Res),
    .L     (L),
    .R     (R),
`ifdef TURN_SIGNAL_BRAKE_EN
    .Brake (Brake),
`endif
    .LampL (LampL),
    .LampR (LampR),
    .Mode  (Mode)
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] model_out(int mode, int step, bit brk);
    int lo, ro;
    lo = FULL;
    ro = FULL;
    if (mode == 1) lo = (step < LAMPS) ? ((FULL << (step + 1)) & FULL) : FULL;
    if (mode == 2) ro = (step < LAMPS) ? ((FULL << (step + 1)) & FULL) : FULL;
    if (mode == 3) begin
      lo = (step == 0) ? 0 : FULL;
      ro = lo;
    end
`ifdef TURN_SIGNAL_BRAKE_EN
    if (brk && mode != 3) begin
      if (mode != 1) lo = 0;
      if (mode != 2) ro = 0;
    end
`endif
    return {2'(mode), 3'(lo), 3'(ro)};
  endfunction

  task automatic drive(input bit res, input bit l, input bit r, input bit b);
    int nm;
    @(negedge Clk);
    Res   = res;
    L     = l;
    R     = r;
    Brake = b;
    if (!res) begin
      m_phase = 0;
      m_mode  = 0;
      m_step  = 0;
      exp_q.push_back({2'd0, 3'b111, 3'b111});
    end else begin
      if (m_phase == TD - 1) begin
        nm = (l && r) ? 3 : l ? 1 : r ? 2 : 0;
        if (nm != m_mode) m_step = 0;
        else if (nm == 3) m_step = (m_step + 1) % 2;
        else m_step = (m_step + 1) % (LAMPS + 1);
        m_mode = nm;
      end
      m_phase = (m_phase + 1) % TD;
      exp_q.push_back(model_out(m_mode, m_step, b));
    end
  endtask

  // Monitor: outputs are valid every cycle; compare one expectation per edge.
  initial begin
    logic [7:0] e, got;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {Mode, LampL, LampR};
        tests++;
        if (got !== e) begin
          failed++;
          $display("FAIL out t=%0t: got mode=%0d L=%b R=%b, expected mode=%0d L=%b R=%b",
                   $time, got[7:6], got[5:3], got[2:0], e[7:6], e[5:3], e[2:0]);
        end
      end
    end
  end

  initial begin
    bit rl, rr, rb;
    int len;
    // Reset
    repeat (3) drive(0, 0, 0, 0);
    // Left sequence through wrap
    repeat (12) drive(1, 1, 0, 0);
    // Hazard, then drop R
    repeat (8) drive(1, 1, 1, 0);
    repeat (4) drive(1, 1, 0, 0);
    // Right, reset mid-run, release with R still held
    repeat (4) drive(1, 0, 1, 0);
    drive(0, 0, 1, 0);
    repeat (6) drive(1, 0, 1, 0);
    // Idle, then one-cycle L pulse on a non-tick edge
    repeat (4) drive(1, 0, 0, 0);
    if (m_phase == TD - 1) drive(1, 0, 0, 0);
    drive(1, 1, 0, 0);
    repeat (4) drive(1, 0, 0, 0);
`ifdef TURN_SIGNAL_BRAKE_EN
    repeat (10) drive(1, 1, 0, 1);
    repeat (6) drive(1, 1, 1, 1);
    repeat (4) drive(1, 0, 0, 1);
`endif
    // Randomized segments
    for (int s = 0; s < 120; s++) begin
      rl  = 1'($urandom_range(0, 1));
      rr  = 1'($urandom_range(0, 1));
      rb  = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 12));
      if ($urandom_range(0, 19) == 0) begin
        repeat (int'($urandom_range(1, 3))) drive(0, rl, rr, rb);
      end
      repeat (len) drive(1, rl, rr, rb);
    end
    repeat (2) @(posedge Clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/turn_signal_seq.md
TURN_SIGNAL_SEQ -- requirements
Module: turn_signal_seq

Interface
REQ-001 SHALL provide parameter LAMPS, default 3, meaning the number of lamps per side (range 2..8).
REQ-002 SHALL provide parameter TICK_DIV, default 25_000_000, meaning Clk cycles per sequence step (range 2..2^26).
REQ-003 SHALL have port Clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port Res, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port L, input, 1 bit: left-turn request, level-sensitive.
REQ-006 SHALL have port R, input, 1 bit: right-turn request, level-sensitive.
REQ-007 SHALL have port LampL, output, LAMPS bits: left lamp drive, active-low (0 = lit), bit 0 innermost.
REQ-008 SHALL have port LampR, output, LAMPS bits: right lamp drive, active-low, bit 0 innermost.
REQ-009 SHALL have port Mode, output, 2 bits: current state encoding (IDLE=0, LEFT=1, RIGHT=2, HAZARD=3).

Function
REQ-010 SHALL contain a prescaler counting 0..TICK_DIV-1 that wraps to 0 and asserts an internal tick on the terminal count.
REQ-011 SHALL contain a step counter of width clog2(LAMPS+1) that changes only on tick.
REQ-012 SHALL implement a state machine with states IDLE, LEFT, RIGHT and HAZARD that changes state only on tick.
REQ-013 On tick, the next state SHALL be HAZARD if L&R, LEFT if L&!R, RIGHT if !L&R, and IDLE if !L&!R.
REQ-014 On tick, when the next state differs from the current state, the step counter SHALL load 0; otherwise it SHALL advance, wrapping LAMPS->0 in LEFT/RIGHT and 1->0 in HAZARD.
REQ-015 In LEFT at step k<LAMPS, LampL bits 0..k SHALL be 0 and all other bits 1; at step LAMPS all bits SHALL be 1; LampR SHALL be all 1s.
REQ-016 RIGHT SHALL behave as REQ-015 with the two sides swapped.
REQ-017 In HAZARD, both sides SHALL be all 0s at step 0 and all 1s at step 1.
REQ-018 In IDLE, both sides SHALL be all 1s.
REQ-019 LampL, LampR and Mode SHALL be registered and SHALL reflect the new state/step on the cycle after the tick.
REQ-020 Request changes between ticks SHALL have no effect until the next tick; a request pulse that misses every tick SHALL be ignored.
REQ-021 The prescaler SHALL run continuously, including in IDLE, so that entry latency is at most TICK_DIV cycles.

Reset
REQ-022 While Res=0 at a rising Clk edge: state=IDLE, step=0, prescaler=0, LampL/LampR all 1s, Mode=0.
REQ-023 Reset asserted mid-sequence SHALL take effect at the next edge regardless of tick; after release, the first tick SHALL occur TICK_DIV cycles later.

Configuration
REQ-024 With macro TURN_SIGNAL_BRAKE_EN defined, the block SHALL add input Brake (1 bit, active-high).
REQ-025 With TURN_SIGNAL_BRAKE_EN defined, while Brake=1 every lamp side not driven by LEFT/RIGHT sequencing SHALL be forced all 0s, combinationally ORed into the registered output path within one cycle; HAZARD SHALL override Brake.
REQ-026 Without TURN_SIGNAL_BRAKE_EN, the Brake port and its logic SHALL be absent, and behaviour SHALL be exactly REQ-010..REQ-023.

Structure
REQ-027 Package turn_signal_pkg SHALL hold the state enum (IDLE, LEFT, RIGHT, HAZARD) and the LAMP_OFF/LAMP_ON polarity constants.
REQ-028 The prescaler SHALL be a sub-module tick_gen, parameterised by TICK_DIV, with outputs tick and Clk/Res ports.
REQ-029 The FSM, step counter and lamp decode SHALL reside in turn_signal_seq.

Verification (LAMPS=3, TICK_DIV=2)
REQ-030 Reset test: Res=0 for 3 cycles -> LampL=LampR=3'b111, Mode=0.
REQ-031 Left sequence: L=1 held -> successive ticks give LampL 110, 100, 000, 111, 110; LampR stays 111.
REQ-032 Hazard: L=R=1 -> both sides alternate 000/111 each tick; dropping R mid-hazard -> next tick Mode=1 and LampL=110.
REQ-033 Reset mid-run: Res=0 while LampR=100 -> next edge all 1s, Mode=0; with R still 1 after release -> LampR=110 after 2 cycles plus 1.
REQ-034 Glitch: one-cycle L pulse placed between ticks -> Mode stays 0.
REQ-035 Brake (TURN_SIGNAL_BRAKE_EN): Brake=1 with L=1 -> LampR=000 while LampL sequences; with L=R=1 -> pure hazard pattern.
